// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority, long-latency results queue and drain on idle cycles.
// Optional same-cycle bypass of an empty queue is enabled by defining WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_we,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_wdata,
   output logic            pipe_stall,
   input  logic            ldu_valid,
   input  logic [4:0]      ldu_rd,
   input  logic [XLEN-1:0] ldu_wdata,
   output logic            ldu_ready,
   output logic [31:0]     pend_mask,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {
      GNT_NONE,
      GNT_FORCE,
      GNT_PIPE,
      GNT_FIFO,
      GNT_BYP
   } grant_e;

   grant_e          grant;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [4:0]      ent_rd_q   [DEPTH];
   logic [4:0]      ent_rd_d   [DEPTH];
   logic [XLEN-1:0] ent_data_q [DEPTH];
   logic [XLEN-1:0] ent_data_d [DEPTH];

   logic empty, full, pipe_hit, force_drain, byp, ready, push, pop;
   logic [31:0] mask;

   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == CW'(DEPTH));
      pipe_hit    = pipe_we && (pipe_rd != '0);
      force_drain = (starve_q == SW'(STARVE_MAX)) && !empty;
`ifdef WB_ARB_BYPASS_EN
      byp         = empty && !pipe_hit && ldu_valid && (ldu_rd != '0);
`else
      byp         = 1'b0;
`endif
      ready       = !full || byp;

      if (force_drain)   grant = GNT_FORCE;
      else if (pipe_hit) grant = GNT_PIPE;
      else if (!empty)   grant = GNT_FIFO;
      else if (byp)      grant = GNT_BYP;
      else               grant = GNT_NONE;

      pop  = (grant == GNT_FORCE) || (grant == GNT_FIFO);
      // x0 results are accepted but dropped; bypassed results never occupy an entry
      push = ldu_valid && ready && (ldu_rd != '0) && !byp;
   end

   always_comb begin
      pipe_stall = 1'b0;
      rf_we      = 1'b0;
      rf_waddr   = '0;
      rf_wdata   = '0;
      ldu_ready  = 1'b0;
      pend_mask  = '0;
      mask       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) mask = mask | (32'd1 << ent_rd_q[i]);
      end
      if (rst_n) begin
         ldu_ready = ready;
         pend_mask = mask;
         unique case (grant)
            GNT_FORCE: begin
               pipe_stall = 1'b1;
               rf_we      = 1'b1;
               rf_waddr   = ent_rd_q[rd_ptr_q];
               rf_wdata   = ent_data_q[rd_ptr_q];
            end
            GNT_PIPE: begin
               rf_we    = 1'b1;
               rf_waddr = pipe_rd;
               rf_wdata = pipe_wdata;
            end
            GNT_FIFO: begin
               rf_we    = 1'b1;
               rf_waddr = ent_rd_q[rd_ptr_q];
               rf_wdata = ent_data_q[rd_ptr_q];
            end
            GNT_BYP: begin
               rf_we    = 1'b1;
               rf_waddr = ldu_rd;
               rf_wdata = ldu_wdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      vld_d      = vld_q;
      ent_rd_d   = ent_rd_q;
      ent_data_d = ent_data_q;

      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      if (push) begin
         vld_d[wr_ptr_q]      = 1'b1;
         ent_rd_d[wr_ptr_q]   = ldu_rd;
         ent_data_d[wr_ptr_q] = ldu_wdata;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (empty || pop)                         starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))     starve_d = starve_q + SW'(1);
      else                                      starve_d = starve_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         vld_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         vld_q    <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter (default build, bypass disabled).
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wdata;
   logic        pipe_stall;
   logic        ldu_valid;
   logic [4:0]  ldu_rd;
   logic [31:0] ldu_wdata;
   logic        ldu_ready;
   logic [31:0] pend_mask;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   typedef struct {
      int unsigned row;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        stall;
      logic        rdy;
      logic [31:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int unsigned row_no = 0;

   localparam logic [31:0] PD   = 32'h3000_0003;
   localparam logic [31:0] PD8  = 32'h8000_0008;
   localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
   localparam logic [31:0] D7   = 32'h7777_7777;
   localparam logic [31:0] D9   = 32'h9999_9999;
   localparam logic [31:0] DB   = 32'hBBBB_BBBB;
   localparam logic [31:0] D6   = 32'h6666_6666;
   localparam logic [31:0] DC   = 32'hCCCC_CCCC;

   wb_port_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_MAX(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pipe_we    (pipe_we),
      .pipe_rd    (pipe_rd),
      .pipe_wdata (pipe_wdata),
      .pipe_stall (pipe_stall),
      .ldu_valid  (ldu_valid),
      .ldu_rd     (ldu_rd),
      .ldu_wdata  (ldu_wdata),
      .ldu_ready  (ldu_ready),
      .pend_mask  (pend_mask),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int unsigned row,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
      end
   endtask

   // Monitor: outputs are combinational on the current cycle's inputs, so sample mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rf_we",      e.row, 32'(rf_we),      32'(e.we));
            chk("rf_waddr",   e.row, 32'(rf_waddr),   32'(e.addr));
            chk("rf_wdata",   e.row, rf_wdata,        e.data);
            chk("pipe_stall", e.row, 32'(pipe_stall), 32'(e.stall));
            chk("ldu_ready",  e.row, 32'(ldu_ready),  32'(e.rdy));
            chk("pend_mask",  e.row, pend_mask,       e.mask);
         end
      end
   end

   task automatic row(input logic rst, input logic pwe, input logic [4:0] prd,
                      input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ld, input logic ewe, input logic [4:0] ea,
                      input logic [31:0] ed, input logic es, input logic er,
                      input logic [31:0] em);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n      = rst;
      pipe_we    = pwe;
      pipe_rd    = prd;
      pipe_wdata = pd;
      ldu_valid  = lv;
      ldu_rd     = lrd;
      ldu_wdata  = ld;
      row_no++;
      e.row   = row_no;
      e.we    = ewe;
      e.addr  = ea;
      e.data  = ed;
      e.stall = es;
      e.rdy   = er;
      e.mask  = em;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                       input logic [31:0] em);
      row(1, 0, 0, '0, 0, 0, '0, ewe, ea, ed, 0, 1, em);
   endtask

   initial begin
      rst_n = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_wdata = '0;
      ldu_valid = 1'b0; ldu_rd = '0; ldu_wdata = '0;

      // reset held with toggling inputs
      row(0, 1, 3, PD, 1, 5, 32'h1, 0, 0, '0, 0, 0, '0);
      row(0, 0, 0, '0, 1, 9, 32'h2, 0, 0, '0, 0, 0, '0);
      idle(0, 0, '0, '0);
      // idle drain, one-cycle enqueue latency
      row(1, 0, 0, '0, 1, 5, BEEF, 0, 0, '0, 0, 1, '0);
      idle(1, 5, BEEF, 32'h0000_0020);
      idle(0, 0, '0, '0);
      // pipeline priority, fill to full
      row(1, 1, 3, PD, 1, 7, D7, 1, 3, PD, 0, 1, '0);
      row(1, 1, 3, PD, 1, 9, D9, 1, 3, PD, 0, 1, 32'h0000_0080);
      for (int i = 0; i < 3; i++)
         row(1, 1, 3, PD, 1, 11, DB, 1, 3, PD, 0, 0, 32'h0000_0280);
      // starvation force of rd7, stall one cycle
      row(1, 1, 3, PD, 1, 11, DB, 1, 7, D7, 1, 0, 32'h0000_0280);
      for (int i = 0; i < 4; i++)
         row(1, 1, 3, PD, 0, 0, '0, 1, 3, PD, 0, 1, 32'h0000_0200);
      row(1, 1, 3, PD, 0, 0, '0, 1, 9, D9, 1, 1, 32'h0000_0200);
      row(1, 1, 3, PD, 0, 0, '0, 1, 3, PD, 0, 1, '0);
      idle(0, 0, '0, '0);
      // x0 on both sources
      row(1, 1, 0, 32'h0000_ABCD, 1, 0, 32'h1, 0, 0, '0, 0, 1, '0);
      idle(0, 0, '0, '0);
      // pipeline x0 cycle lets the queue drain
      row(1, 0, 0, '0, 1, 6, D6, 0, 0, '0, 0, 1, '0);
      row(1, 1, 0, 32'h0000_ABCD, 0, 0, '0, 1, 6, D6, 0, 1, 32'h0000_0040);
      idle(0, 0, '0, '0);
      // duplicates of rd4 with pointer wrap
      row(1, 0, 0, '0, 1, 4, 32'h4000_0001, 0, 0, '0, 0, 1, '0);
      row(1, 0, 0, '0, 1, 4, 32'h4000_0002, 1, 4, 32'h4000_0001, 0, 1, 32'h0000_0010);
      row(1, 0, 0, '0, 1, 4, 32'h4000_0003, 1, 4, 32'h4000_0002, 0, 1, 32'h0000_0010);
      row(1, 0, 0, '0, 1, 4, 32'h4000_0004, 1, 4, 32'h4000_0003, 0, 1, 32'h0000_0010);
      row(1, 1, 8, PD8, 1, 4, 32'h4000_0005, 1, 8, PD8, 0, 1, 32'h0000_0010);
      row(1, 0, 0, '0, 0, 0, '0, 1, 4, 32'h4000_0004, 0, 0, 32'h0000_0010);
      row(1, 0, 0, '0, 1, 4, 32'h4000_0006, 1, 4, 32'h4000_0005, 0, 1, 32'h0000_0010);
      idle(1, 4, 32'h4000_0006, 32'h0000_0010);
      idle(0, 0, '0, '0);
      // reset mid-operation discards the queued entry
      row(1, 0, 0, '0, 1, 12, DC, 0, 0, '0, 0, 1, '0);
      row(0, 1, 3, PD, 0, 0, '0, 0, 0, '0, 0, 0, '0);
      idle(0, 0, '0, '0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
